pc_uart_rx: RTL and testbench
=============================

# pc_uart_rx

Receive-only 8N1 UART front end for the PC/configurator serial link. It samples the asynchronous `pc_rx_pin` line, validates start, data and stop bits with 3-sample majority voting, and delivers each good byte as a single-cycle `pc_rx_data`/`pc_rx_valid` strobe. That strobe drives the MSP passthrough sniffer inside `wb_serial_dshot_mux` directly. The block also reports framing errors and line-break conditions for diagnostics.

## Interface
- `CLK_FREQ_HZ`, default 72_000_000: system clock frequency.
- `BAUD`, default 115_200: line rate. Derived `DIV = CLK_FREQ_HZ/BAUD` is integer-truncated (625 at the defaults); `HALF = DIV/2`. Elaboration fails if `DIV < 8`.
- `wb_clk_i`  in  1: the single system clock; all logic sits in this domain.
- `wb_rst_ni`  in  1: asynchronous, active-low reset.
- `pc_rx_pin`  in  1: raw asynchronous serial line; idle high.
- `pc_rx_data`  out  8: last good byte; held stable until the next good byte.
- `pc_rx_valid`  out  1: single-cycle strobe marking a new `pc_rx_data`.
- `frame_err_o`  out  1: single-cycle strobe when the stop bit samples low.
- `break_o`  out  1: level; high while a break condition persists.
- `busy_o`  out  1: high in any state other than IDLE.

## Operation
- Input synchronizer: 2-FF, both flops reset to 1. The result `rx_s` is the only signal the FSM reads.
- Bit counter `cnt` counts 0..DIV-1, then wraps to 0. `bit_idx` is 0..9, where 0 is the start bit, 1-8 are data bits LSB first, and 9 is the stop bit.
- Majority vote:
  - samples `rx_s` at cnt = HALF-1, HALF and HALF+1;
  - the voted bit is 2-of-3;
  - the decision is taken at cnt = HALF+1.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rx_s` is 0 (previous cycle 1), go to START with cnt = 0 and bit_idx = 0.
  - START: at the decision point, a voted 0 goes to DATA; a voted 1 is a glitch and returns to IDLE with no output. cnt keeps running.
  - DATA: at each decision point, shift the voted bit into bit 7 of the shift register (right shift). After bit_idx 8, go to STOP.
  - STOP:
    - voted 1: load `pc_rx_data` from the shift register, pulse `pc_rx_valid` on the next cycle, go to IDLE.
    - voted 0: pulse `frame_err_o`, go to WAIT_HIGH; `pc_rx_data` is unchanged.
  - WAIT_HIGH: stays until `rx_s` has been 1 for DIV consecutive cycles, then goes to IDLE. This prevents re-triggering inside a corrupt frame.
- Break detection:
  - `break_o` sets when `rx_s` has been continuously low for 10·DIV cycles, counted from the falling edge. This sets it during WAIT_HIGH.
  - It clears on the first cycle `rx_s` is 1.
  - A break never produces `pc_rx_valid`.
- No backpressure and no buffering: the consumer must accept every strobe. Strobes are at least 10·DIV−HALF cycles apart.

## Timing
- Reset values: `pc_rx_data` = 8'h00; `pc_rx_valid`, `frame_err_o`, `break_o` and `busy_o` = 0; FSM = IDLE; synchronizer = 1. Reset is asynchronous assert, released synchronously through a standard async-reset flop on the first clock.
- Latency: `pc_rx_valid` rises 9·DIV + HALF + 2 cycles after the first cycle `rx_s` is low. Add 2 cycles of synchronizer delay when measuring from the pin.
- `frame_err_o` follows the same timing as `pc_rx_valid`.
- `pc_rx_valid` and `frame_err_o` are mutually exclusive in every cycle.
- Back-to-back frames with a single stop bit are received without loss. The FSM is in IDLE HALF−1 cycles before the next start edge.
- Reset asserted mid-frame: everything returns to reset values immediately, and no strobe is issued for the partial frame.
- Tolerates ±3% baud mismatch at `DIV` ≥ 100.

## Structure
- Package `pc_uart_pkg` holds:
  - the `uart_rx_state_e` enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - constant `UART_FRAME_BITS = 10`;
  - function `uart_div(clk_hz, baud)`.
- One sub-module, `sync_2ff`, a generic reset-to-value synchronizer. It is reused by other pad inputs.
- Top-level integration wires `pc_rx_data`/`pc_rx_valid` straight to the mux ports of the same name.

## Test plan
- Send 0x24 (`$`) at 115200 baud → exactly one `pc_rx_valid` pulse with `pc_rx_data` = 8'h24, at 9·625 + 312 + 4 cycles from the pin falling edge.
- Send `$`, `M`, `<`, 0x00, 0xF5 back-to-back with no idle gap → five strobes carrying 24, 4D, 3C, 00, F5 in order; the `wb_serial_dshot_mux` sniffer switches `mux_sel` to 0.
- Drive a 200 ns low glitch on the idle line → no `pc_rx_valid`, no `frame_err_o`, and `busy_o` returns to 0 within HALF+2 cycles.
- Send 0x55 with the stop bit forced low and the line then high → one `frame_err_o` pulse, no `pc_rx_valid`, `pc_rx_data` unchanged; the next good byte 0xA5 is received correctly.
- Hold the line low for 2 ms → `break_o` high from 10·625 cycles after the edge until the line rises, with a single `frame_err_o` and no `pc_rx_valid`.
- Assert `wb_rst_ni` during data bit 4 of 0x3C, release it, then send 0x4D at +3% and at −3% baud → no strobe for the aborted frame, and 8'h4D received correctly at both rates.

Source files
------------

// File: rtl/pc_uart_pkg.sv
// Shared types and helpers for the PC serial receive path.
package pc_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_e;

    localparam int unsigned UART_FRAME_BITS = 10;

    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs, resetting to a chosen value.
module sync_2ff #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pc_uart_rx.sv
// 8N1 receiver for the PC/configurator link: 3-sample majority voting,
// single-cycle byte strobe, framing-error strobe and break level.
module pc_uart_rx
    import pc_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 72_000_000,
    parameter int unsigned BAUD        = 115_200
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic       pc_rx_pin,
    output logic [7:0] pc_rx_data,
    output logic       pc_rx_valid,
    output logic       frame_err_o,
    output logic       break_o,
    output logic       busy_o
);

    localparam int unsigned DIV        = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int unsigned HALF       = DIV / 2;
    localparam int unsigned CNT_W      = $clog2(DIV);
    localparam int unsigned BRK_CYCLES = UART_FRAME_BITS * DIV;
    localparam int unsigned BRK_W      = $clog2(BRK_CYCLES);

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BRK_CYCLES - 1);

    if (DIV < 8) begin : g_div_check
        $error("pc_uart_rx: CLK_FREQ_HZ/BAUD must be at least 8");
    end

    logic                 rx_s;
    logic                 rx_prev;
    uart_rx_state_e       state;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_idx;
    logic                 s0;
    logic                 s1;
    logic                 vote;
    logic [7:0]           shreg;
    logic [BRK_W-1:0]     low_cnt;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .d     (pc_rx_pin),
        .q     (rx_s)
    );

    // Third sample is the live rx_s at the decision count.
    always_comb begin
        vote = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            s0          <= 1'b1;
            s1          <= 1'b1;
            shreg       <= '0;
            rx_prev     <= 1'b1;
            pc_rx_data  <= '0;
            pc_rx_valid <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_prev     <= rx_s;
            pc_rx_valid <= 1'b0;
            frame_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The detection cycle itself is bit-time count 0.
                    if (!rx_s && rx_prev) begin
                        state   <= START;
                        cnt     <= CNT_W'(1);
                        bit_idx <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!rx_s) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (cnt == CNT_S0) s0 <= rx_s;
                    if (cnt == CNT_S1) s1 <= rx_s;
                    if (cnt == CNT_DEC) begin
                        case (state)
                            START: state <= vote ? IDLE : DATA;
                            DATA: begin
                                shreg <= {vote, shreg[7:1]};
                                if (bit_idx == 4'd8) state <= STOP;
                            end
                            STOP: begin
                                if (vote) begin
                                    pc_rx_data  <= shreg;
                                    pc_rx_valid <= 1'b1;
                                    state       <= IDLE;
                                end else begin
                                    frame_err_o <= 1'b1;
                                    state       <= WAIT_HIGH;
                                    cnt         <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            low_cnt <= '0;
            break_o <= 1'b0;
        end else if (rx_s) begin
            low_cnt <= '0;
            break_o <= 1'b0;
        end else if (low_cnt == BRK_LAST) begin
            break_o <= 1'b1;
        end else begin
            low_cnt <= low_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_uart_rx.sv
// Directed bench for pc_uart_rx at DIV = 100 (HALF = 50).
module tb_pc_uart_rx;

    localparam int unsigned DIV  = 100;
    localparam int unsigned HALF = 50;
    localparam int unsigned LAT  = 9 * DIV + HALF + 4;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_ni = 1'b0;
    logic       pc_rx_pin = 1'b1;
    logic [7:0] pc_rx_data;
    logic       pc_rx_valid;
    logic       frame_err_o;
    logic       break_o;
    logic       busy_o;

    pc_uart_rx #(
        .CLK_FREQ_HZ (11_520_000),
        .BAUD        (115_200)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .pc_rx_pin   (pc_rx_pin),
        .pc_rx_data  (pc_rx_data),
        .pc_rx_valid (pc_rx_valid),
        .frame_err_o (frame_err_o),
        .break_o     (break_o),
        .busy_o      (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned valid_cnt = 0;
    int unsigned ferr_cnt = 0;
    int unsigned both_cnt = 0;
    int unsigned last_valid_cyc = 0;
    int unsigned last_ferr_cyc = 0;
    int unsigned frame_start = 0;
    logic [7:0]  got [0:31];

    always @(posedge wb_clk_i) cyc++;

    always @(negedge wb_clk_i) begin
        if (pc_rx_valid) begin
            if (valid_cnt < 32) got[valid_cnt] = pc_rx_data;
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (frame_err_o) begin
            ferr_cnt++;
            last_ferr_cyc = cyc;
        end
        if (pc_rx_valid && frame_err_o) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned bit_cyc, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        frame_start = cyc;
        for (int unsigned i = 0; i < 10; i++) begin
            pc_rx_pin = frame[i];
            wait_cyc(bit_cyc);
        end
        pc_rx_pin = 1'b1;
    endtask

    initial begin
        logic [7:0] seq [0:4];
        logic [9:0] abort_frame;
        int unsigned c0;
        seq[0] = 8'h24; seq[1] = 8'h4D; seq[2] = 8'h3C; seq[3] = 8'h00; seq[4] = 8'hF5;

        wait_cyc(3);
        check("rst_data",  32'(pc_rx_data), 32'h00);
        check("rst_valid", 32'(pc_rx_valid), 32'h0);
        check("rst_ferr",  32'(frame_err_o), 32'h0);
        check("rst_break", 32'(break_o), 32'h0);
        check("rst_busy",  32'(busy_o), 32'h0);
        wb_rst_ni = 1'b1;
        wait_cyc(20);

        // Single '$' and its latency from the pin edge
        send_byte(8'h24, DIV, 1'b1);
        wait_cyc(50);
        check("single_cnt",  valid_cnt, 32'd1);
        check("single_data", 32'(got[0]), 32'h24);
        check("single_lat",  last_valid_cyc - frame_start, LAT);
        check("single_busy", 32'(busy_o), 32'h0);

        // Back-to-back frames, single stop bit, no gap
        for (int unsigned k = 0; k < 5; k++) send_byte(seq[k], DIV, 1'b1);
        wait_cyc(50);
        check("b2b_cnt", valid_cnt, 32'd6);
        for (int unsigned k = 0; k < 5; k++) check("b2b_data", 32'(got[k+1]), 32'(seq[k]));
        wait_cyc(100);

        // Short glitch on idle line
        c0 = cyc;
        pc_rx_pin = 1'b0;
        wait_cyc(14);
        pc_rx_pin = 1'b1;
        wait_cyc(c0 + HALF + 3 - cyc);
        check("glitch_busy_hi", 32'(busy_o), 32'h1);
        wait_cyc(1);
        check("glitch_busy_lo", 32'(busy_o), 32'h0);
        wait_cyc(200);
        check("glitch_valid", valid_cnt, 32'd6);
        check("glitch_ferr",  ferr_cnt, 32'd0);

        // Framing error on 0x55, then a good 0xA5
        send_byte(8'h55, DIV, 1'b0);
        wait_cyc(250);
        check("ferr_cnt",   ferr_cnt, 32'd1);
        check("ferr_lat",   last_ferr_cyc - frame_start, LAT);
        check("ferr_valid", valid_cnt, 32'd6);
        check("ferr_data",  32'(pc_rx_data), 32'hF5);
        send_byte(8'hA5, DIV, 1'b1);
        wait_cyc(50);
        check("after_ferr_cnt",  valid_cnt, 32'd7);
        check("after_ferr_data", 32'(got[6]), 32'hA5);
        wait_cyc(100);

        // Break: line low for 20 bit times
        c0 = cyc;
        pc_rx_pin = 1'b0;
        wait_cyc(10 * DIV + 1);
        check("break_pre",  32'(break_o), 32'h0);
        wait_cyc(1);
        check("break_set",  32'(break_o), 32'h1);
        wait_cyc(c0 + 20 * DIV - cyc);
        check("break_hold", 32'(break_o), 32'h1);
        pc_rx_pin = 1'b1;
        wait_cyc(5);
        check("break_clr",   32'(break_o), 32'h0);
        wait_cyc(200);
        check("break_ferr",  ferr_cnt, 32'd2);
        check("break_valid", valid_cnt, 32'd7);
        check("break_busy",  32'(busy_o), 32'h0);

        // Reset during data bit 4 of 0x3C
        abort_frame = {1'b1, 8'h3C, 1'b0};
        for (int unsigned i = 0; i < 5; i++) begin
            pc_rx_pin = abort_frame[i];
            wait_cyc(DIV);
        end
        pc_rx_pin = abort_frame[5];
        wait_cyc(HALF);
        wb_rst_ni = 1'b0;
        #1;
        check("abort_busy", 32'(busy_o), 32'h0);
        check("abort_data", 32'(pc_rx_data), 32'h00);
        wait_cyc(3);
        pc_rx_pin = 1'b1;
        wait_cyc(2);
        wb_rst_ni = 1'b1;
        wait_cyc(1200);
        check("abort_valid", valid_cnt, 32'd7);
        check("abort_ferr",  ferr_cnt, 32'd2);

        // 0x4D at +3% and -3% baud
        send_byte(8'h4D, 97, 1'b1);
        wait_cyc(100);
        check("fast_cnt",  valid_cnt, 32'd8);
        check("fast_data", 32'(got[7]), 32'h4D);
        send_byte(8'h4D, 103, 1'b1);
        wait_cyc(100);
        check("slow_cnt",  valid_cnt, 32'd9);
        check("slow_data", 32'(got[8]), 32'h4D);
        check("slow_ferr", ferr_cnt, 32'd2);

        check("valid_ferr_exclusive", both_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
